// File: rtl/dma_engine.sv
// dma_engine: DMAB/DMAW engine moving bytes/words between data RAM and a 32-bit stream port; optional DMA_IRQ_EN adds irq/irq_clr
`ifndef BYTE
`define BYTE 4'b0001
`endif
`ifndef FULLWORD
`define FULLWORD 4'b0100
`endif
module dma_engine #(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_grant,
  input  logic [2:0]        dma_type,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_len,
  output logic              dma_status,
  output logic              dma_done,
  output logic              dma_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_ram_type,
  input  logic              mem_gnt,
  input  logic [31:0]       mem_rdata,
  output logic              tx_valid,
  output logic [31:0]       tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [31:0]       rx_data,
  output logic              rx_ready
`ifdef DMA_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_clr
`endif
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] TX      = 3'd3;
  localparam logic [2:0] RX      = 3'd4;
  localparam logic [2:0] WR_REQ  = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  logic [2:0]        state;
  logic              is_rd, is_word, err_q;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  cnt;
  logic [31:0]       data_q;
  logic              valid_type, word_type, rd_type, misaligned, last;
  logic [ADDR_W-1:0] next_addr;
  logic [2:0]        next_elem;
  logic [7:0]        lane;
  logic              unused_len;
  assign unused_len = ^dma_len[31:LEN_W];
  // decode of the incoming instruction and per-element bookkeeping
  always_comb begin
    valid_type = dma_type >= 3'd1 && dma_type <= 3'd4;
    word_type  = dma_type == 3'd3 || dma_type == 3'd4;
    rd_type    = dma_type == 3'd1 || dma_type == 3'd3;
    misaligned = word_type && dma_addr[1:0] != 2'b00;
    last       = cnt == LEN_W'(1);
    next_addr  = addr + ADDR_W'(is_word ? 4 : 1);
    next_elem  = last ? DONE : (is_rd ? RD_REQ : RX);
    lane       = mem_rdata[{addr[1:0], 3'b000} +: 8];
  end
  // transfer sequencer: one RAM access and one stream handshake per element
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      is_rd   <= 1'b0;
      is_word <= 1'b0;
      err_q   <= 1'b0;
      addr    <= '0;
      cnt     <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: if (dma_grant && valid_type) begin
          is_rd   <= rd_type;
          is_word <= word_type;
          err_q   <= misaligned;
          addr    <= dma_addr;
          cnt     <= dma_len[LEN_W-1:0];
          state   <= (misaligned || dma_len[LEN_W-1:0] == '0) ? DONE : (rd_type ? RD_REQ : RX);
        end
        RD_REQ: if (mem_gnt) state <= RD_WAIT;
        RD_WAIT: begin
          data_q <= is_word ? mem_rdata : {24'b0, lane};
          state  <= TX;
        end
        TX: if (tx_ready) begin
          cnt   <= cnt - LEN_W'(1);
          addr  <= next_addr;
          state <= next_elem;
        end
        RX: if (rx_valid) begin
          data_q <= rx_data;
          state  <= WR_REQ;
        end
        WR_REQ: if (mem_gnt) begin
          cnt   <= cnt - LEN_W'(1);
          addr  <= next_addr;
          state <= next_elem;
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // outputs decoded straight from state so a reset clears them on the next cycle
  always_comb begin
    dma_status   = state != IDLE && state != DONE;
    dma_done     = state == DONE;
    dma_err      = state == DONE && err_q;
    mem_req      = state == RD_REQ || state == WR_REQ;
    mem_we       = state == WR_REQ;
    mem_addr     = addr;
    mem_wdata    = is_word ? data_q : {24'b0, data_q[7:0]};
    mem_ram_type = mem_req ? (is_word ? `FULLWORD : `BYTE) : 4'b0000;
    tx_valid     = state == TX;
    tx_data      = data_q;
    rx_ready     = state == RX;
  end
`ifdef DMA_IRQ_EN
  // sticky completion interrupt; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else if (state == DONE) irq <= 1'b1;
    else if (irq_clr) irq <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: directed self-checking bench for dma_engine
`ifndef BYTE
`define BYTE 4'b0001
`endif
`ifndef FULLWORD
`define FULLWORD 4'b0100
`endif
module tb_dma_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dma_grant = 1'b0;
  logic [2:0]  dma_type = '0;
  logic [31:0] dma_addr = '0;
  logic [31:0] dma_len = '0;
  logic        dma_status, dma_done, dma_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_ram_type;
  logic        mem_gnt = 1'b1;
  logic [31:0] mem_rdata = '0;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready = 1'b1;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_ready;
  logic        tog = 1'b0;
  int tests = 0;
  int fails = 0;
  int reqc = 0;
  logic [31:0] ram [logic [31:0]];
  logic [31:0] ra_q[$], rt_q[$], wa_q[$], wd_q[$], wt_q[$], tx_q[$], rx_q[$];
  always #5 clk = ~clk;
  dma_engine dut (
    .clk(clk), .rst(rst), .dma_grant(dma_grant), .dma_type(dma_type), .dma_addr(dma_addr),
    .dma_len(dma_len), .dma_status(dma_status), .dma_done(dma_done), .dma_err(dma_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ram_type(mem_ram_type), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
  );
  always @(posedge clk) begin
    if (mem_req) reqc <= reqc + 1;
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_wdata);
        wt_q.push_back({28'b0, mem_ram_type});
      end else begin
        ra_q.push_back(mem_addr);
        rt_q.push_back({28'b0, mem_ram_type});
        mem_rdata <= ram.exists(mem_addr >> 2) ? ram[mem_addr >> 2] : 32'h0;
      end
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (rx_valid && rx_ready) void'(rx_q.pop_front());
  end
  always @(negedge clk) begin
    rx_valid = rx_q.size() != 0;
    rx_data = rx_valid ? rx_q[0] : 32'h0;
    if (tog) tx_ready = ~tx_ready;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] qa(input logic [31:0] q[$], input int i);
    return i < q.size() ? q[i] : 32'hDEADBEEF;
  endfunction
  task automatic clr();
    ra_q.delete(); rt_q.delete(); wa_q.delete(); wd_q.delete(); wt_q.delete(); tx_q.delete();
  endtask
  task automatic start(input logic [2:0] t, input logic [31:0] a, input logic [31:0] l);
    @(negedge clk);
    dma_type = t; dma_addr = a; dma_len = l; dma_grant = 1'b1;
    @(negedge clk);
    dma_grant = 1'b0;
  endtask
  task automatic wait_done(output int c);
    c = 0;
    while (!dma_done && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", {31'b0, dma_done}, 32'd1);
  endtask
  initial begin
    int c, r0;
    repeat (3) @(negedge clk);
    chk("rst_status", {31'b0, dma_status}, 0);
    chk("rst_req", {31'b0, mem_req}, 0);
    chk("rst_tx", {31'b0, tx_valid}, 0);
    chk("rst_rx", {31'b0, rx_ready}, 0);
    chk("rst_rt", {28'b0, mem_ram_type}, 0);
    chk("rst_done", {31'b0, dma_done}, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ram[32'h40 + i] = 32'hCAFE_00A0 + i;
    clr();
    start(3, 32'h100, 4);
    chk("t1_status", {31'b0, dma_status}, 1);
    wait_done(c);
    chk("t1_lat", c, 12);
    chk("t1_err", {31'b0, dma_err}, 0);
    chk("t1_ntx", tx_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_tx", qa(tx_q, i), 32'hCAFE_00A0 + i);
    chk("t1_rt", qa(rt_q, 0), {28'b0, `FULLWORD});
    chk("t1_ra3", qa(ra_q, 3), 32'h10C);
    @(negedge clk);
    chk("t1_done_pulse", {31'b0, dma_done}, 0);
    clr();
    rx_q = '{32'hABCDEF11, 32'h00000022, 32'hFFFFFF33};
    start(2, 32'h203, 3);
    wait_done(c);
    chk("t2_lat", c, 6);
    chk("t2_nw", wa_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_wa", qa(wa_q, i), 32'h203 + i);
      chk("t2_wd", qa(wd_q, i), 32'h11 * (i + 1));
      chk("t2_wt", qa(wt_q, i), {28'b0, `BYTE});
    end
    clr();
    r0 = reqc;
    start(4, 32'h102, 8);
    chk("t3_done", {31'b0, dma_done}, 1);
    chk("t3_err", {31'b0, dma_err}, 1);
    chk("t3_status", {31'b0, dma_status}, 0);
    @(negedge clk);
    chk("t3_done_clr", {31'b0, dma_done}, 0);
    chk("t3_err_clr", {31'b0, dma_err}, 0);
    chk("t3_noreq", reqc - r0, 0);
    ram[32'h140] = 32'h44332211;
    clr();
    mem_gnt = 1'b0;
    start(1, 32'h501, 2);
    for (int k = 0; k < 5; k++) begin
      chk("t4_req_hold", {31'b0, mem_req}, 1);
      chk("t4_addr_hold", mem_addr, 32'h501);
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    tog = 1'b1;
    wait_done(c);
    tog = 1'b0;
    tx_ready = 1'b1;
    chk("t4_ntx", tx_q.size(), 2);
    chk("t4_tx0", qa(tx_q, 0), 32'h22);
    chk("t4_tx1", qa(tx_q, 1), 32'h33);
    chk("t4_nrd", ra_q.size(), 2);
    chk("t4_rt", qa(rt_q, 1), {28'b0, `BYTE});
    clr();
    r0 = reqc;
    start(3, 32'h100, 0);
    chk("t5_len0_done", {31'b0, dma_done}, 1);
    chk("t5_len0_err", {31'b0, dma_err}, 0);
    chk("t5_len0_noreq", reqc - r0, 0);
    r0 = reqc;
    start(0, 32'h100, 1);
    chk("t5_type0", {31'b0, dma_status}, 0);
    start(5, 32'h100, 1);
    chk("t5_type5", {31'b0, dma_status}, 0);
    chk("t5_badtype_noreq", reqc - r0, 0);
    clr();
    start(3, 32'h100, 2);
    @(negedge clk);
    start(1, 32'h300, 5);
    wait_done(c);
    chk("t5_ntx", tx_q.size(), 2);
    chk("t5_tx0", qa(tx_q, 0), 32'hCAFE_00A0);
    chk("t5_tx1", qa(tx_q, 1), 32'hCAFE_00A1);
    repeat (2) @(negedge clk);
    chk("t5_idle_after", {31'b0, dma_status}, 0);
    clr();
    start(2, 32'h400, 3);
    @(negedge clk);
    chk("t5_rx_wait", {31'b0, rx_ready}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_status", {31'b0, dma_status}, 0);
    chk("t5_rst_rx", {31'b0, rx_ready}, 0);
    chk("t5_rst_req", {31'b0, mem_req}, 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_done", {31'b0, dma_done}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_nodone", {31'b0, dma_done}, 0);
    ram[32'h3FFFFFFF] = 32'h1111_FFFC;
    ram[32'h0] = 32'h2222_0000;
    clr();
    start(3, 32'hFFFFFFFC, 2);
    wait_done(c);
    chk("t6_lat", c, 6);
    chk("t6_ra0", qa(ra_q, 0), 32'hFFFFFFFC);
    chk("t6_ra1", qa(ra_q, 1), 32'h0);
    chk("t6_tx1", qa(tx_q, 1), 32'h2222_0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
